// File: rtl/mem_responder_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and
// the alignment check used at access time.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10,
        SIZE_BAD  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } state_t;

    // Illegal size is folded in here so the top only adds the range check.
    function automatic logic align_err(size_t size, logic [1:0] lane);
        case (size)
            SIZE_WORD: return lane != 2'b00;
            SIZE_HALF: return lane[0];
            SIZE_BYTE: return 1'b0;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory request/response bundle; master is the CPU, slave the responder.
interface mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder_byte_lane_merge.sv
// Little-endian lane steering: merges store data into the old word and
// extracts right-justified, zero-extended load data from it.
module byte_lane_merge
    import mem_resp_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    input  size_t       i_size,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata
);
    logic [4:0] w_bsh;
    logic [4:0] w_hsh;

    assign w_bsh = {i_lane, 3'b000};
    assign w_hsh = {i_lane[1], 4'b0000};

    always_comb begin
        o_merged = i_old;
        o_rdata  = '0;
        case (i_size)
            SIZE_WORD: begin
                o_merged = i_wdata;
                o_rdata  = i_old;
            end
            SIZE_HALF: begin
                o_merged = (i_old & ~(32'h0000_FFFF << w_hsh))
                         | ({16'h0000, i_wdata[15:0]} << w_hsh);
                o_rdata  = {16'h0000, 16'(i_old >> w_hsh)};
            end
            SIZE_BYTE: begin
                o_merged = (i_old & ~(32'h0000_00FF << w_bsh))
                         | ({24'h000000, i_wdata[7:0]} << w_bsh);
                o_rdata  = {24'h000000, 8'(i_old >> w_bsh)};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: captures one request, waits LATENCY cycles, performs
// the access (sub-word stores as read-modify-write) and strobes one response.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            i_clock,
    input  logic            i_reset,
    mem_responder_if.slave  bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t          r_state, w_next;
    logic            r_write;
    size_t           r_size;
    logic [31:0]     r_addr, r_wdata, r_rdata;
    logic            r_err;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_err, w_ready, w_resp_valid, w_we;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_old, w_merged, w_load;

    assign w_err = align_err(r_size, r_addr[1:0]) || (r_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_idx = r_addr[AW+1:2];
    assign w_old = r_mem[w_idx];
    assign w_we  = (r_state == ACCESS) && r_write && !w_err;

    byte_lane_merge u_merge (
        .i_old    (w_old),
        .i_wdata  (r_wdata),
        .i_size   (r_size),
        .i_lane   (r_addr[1:0]),
        .o_merged (w_merged),
        .o_rdata  (w_load)
    );

    always_comb begin
        w_next       = r_state;
        w_ready      = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.req_valid) w_next = (LATENCY > 0) ? WAIT : ACCESS;
            end
            WAIT:   if (r_cnt == '0) w_next = ACCESS;
            ACCESS: w_next = RESP;
            RESP: begin
                w_resp_valid = 1'b1;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_size  <= SIZE_WORD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_write <= bus.req_write;
                    r_size  <= size_t'(bus.req_size);
                    r_addr  <= bus.req_addr;
                    r_wdata <= bus.req_wdata;
                    r_cnt   <= CNT_LOAD;
                end
                WAIT: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                ACCESS: begin
                    r_err   <= w_err;
                    r_rdata <= (w_err || r_write) ? 32'h0 : w_load;
                end
                RESP: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // One register per word keeps the reset clear a plain per-word assignment.
    for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
        always_ff @(posedge i_clock) begin
            if (i_reset)
                r_mem[g] <= '0;
            else if (w_we && (w_idx == AW'(g)))
                r_mem[g] <= w_merged;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2 and a LATENCY=0 instance.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   n_resp2 = 0;

    always #5 clk = ~clk;

    mem_responder_if b2();
    mem_responder_if b0();

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut2 (
        .i_clock (clk), .i_reset (rst), .bus (b2.slave));
    mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .i_clock (clk), .i_reset (rst), .bus (b0.slave));

    always @(negedge clk) if (b2.resp_valid === 1'b1) n_resp2++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int inst, input logic v, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        if (inst == 0) begin
            b0.req_valid = v; b0.req_write = w; b0.req_size = s; b0.req_addr = a; b0.req_wdata = d;
        end else begin
            b2.req_valid = v; b2.req_write = w; b2.req_size = s; b2.req_addr = a; b2.req_wdata = d;
        end
    endtask

    // Negedges counted from the accept edge to the first negedge with resp_valid high.
    task automatic txn(input int inst, input logic w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
        int n;
        logic rv;
        @(negedge clk);
        chk({tag, "_ready"}, (inst == 0) ? b0.req_ready : b2.req_ready, 1);
        drive(inst, 1'b1, w, s, a, d);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) drive(inst, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            rv = (inst == 0) ? b0.resp_valid : b2.resp_valid;
        end while (rv !== 1'b1 && n < 20);
        chk({tag, "_lat"}, n, (inst == 0) ? 2 : 4);
        chk({tag, "_rdata"}, (inst == 0) ? b0.resp_rdata : b2.resp_rdata, exp_rd);
        chk({tag, "_err"}, (inst == 0) ? b0.resp_err : b2.resp_err, exp_err);
        @(negedge clk);
        chk({tag, "_onecyc"}, (inst == 0) ? b0.resp_valid : b2.resp_valid, 0);
        chk({tag, "_clr"}, (inst == 0) ? {b0.resp_err, b0.resp_rdata} : {b2.resp_err, b2.resp_rdata}, 0);
    endtask

    initial begin
        int acc, r0;
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", b2.req_ready, 1);
        chk("rst_valid", b2.resp_valid, 0);
        chk("rst_rdata", b2.resp_rdata, 0);
        chk("rst_err", b2.resp_err, 0);

        txn(2, 1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0,        0, "st_w10");
        txn(2, 0, 2'b00, 32'h10, 32'h0,        32'hDEADBEEF, 0, "ld_w10");
        txn(2, 1, 2'b10, 32'h11, 32'hFFFFFFAA, 32'h0,        0, "st_b11");
        txn(2, 0, 2'b00, 32'h10, 32'h0,        32'hDEADAAEF, 0, "ld_w10b");
        txn(2, 0, 2'b01, 32'h12, 32'h0,        32'h0000DEAD, 0, "ld_h12");
        txn(2, 0, 2'b10, 32'h13, 32'h0,        32'h000000DE, 0, "ld_b13");
        txn(2, 1, 2'b01, 32'h13, 32'h5555,     32'h0,        1, "st_h13_mis");
        txn(2, 1, 2'b00, 32'h0E, 32'h11111111, 32'h0,        1, "st_w0e_mis");
        txn(2, 0, 2'b00, 32'h10, 32'h0,        32'hDEADAAEF, 0, "ld_w10c");
        txn(2, 0, 2'b00, 32'h400, 32'h0,       32'h0,        1, "ld_oor");
        txn(2, 0, 2'b11, 32'h0,  32'h0,        32'h0,        1, "ld_badsz");
        txn(2, 1, 2'b01, 32'h12, 32'hFFFF1234, 32'h0,        0, "st_h12");
        txn(2, 0, 2'b00, 32'h10, 32'h0,        32'h1234AAEF, 0, "ld_w10d");
        txn(2, 1, 2'b10, 32'h3FF, 32'h0000005A, 32'h0,       0, "st_b3ff");
        txn(2, 0, 2'b00, 32'h3FC, 32'h0,       32'h5A000000, 0, "ld_w3fc");

        // Continuous req_valid: only cycles with req_ready=1 are accepted (i=0,5,10).
        acc = 0;
        r0  = n_resp2;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (b2.req_ready === 1'b1) acc++;
            drive(2, 1'b1, 1'b1, 2'b00, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        end
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (8) @(negedge clk);
        chk("hold_accepts", acc, 3);
        chk("hold_resps", n_resp2 - r0, 3);
        txn(2, 0, 2'b00, 32'h100, 32'h0, 32'hA0, 0, "hold_ld0");
        txn(2, 0, 2'b00, 32'h104, 32'h0, 32'h0,  0, "hold_ld1");
        txn(2, 0, 2'b00, 32'h114, 32'h0, 32'hA5, 0, "hold_ld5");
        txn(2, 0, 2'b00, 32'h128, 32'h0, 32'hAA, 0, "hold_ld10");
        txn(2, 0, 2'b00, 32'h12C, 32'h0, 32'h0,  0, "hold_ld11");

        // Reset during WAIT aborts the store.
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 2'b00, 32'h20, 32'h12345678);
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        rst = 1'b1;
        r0 = n_resp2;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_abort_ready", b2.req_ready, 1);
        repeat (5) @(negedge clk);
        chk("rst_abort_noresp", n_resp2 - r0, 0);
        txn(2, 0, 2'b00, 32'h20, 32'h0, 32'h0, 0, "rst_ld20");
        txn(2, 0, 2'b00, 32'h10, 32'h0, 32'h0, 0, "rst_ld10");

        txn(0, 1, 2'b00, 32'h8, 32'hCAFEF00D, 32'h0,        0, "l0_st_w8");
        txn(0, 0, 2'b01, 32'hA, 32'h0,        32'h0000CAFE, 0, "l0_ld_ha");
        txn(0, 0, 2'b01, 32'h9, 32'h0,        32'h0,        1, "l0_ld_h9");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
